// File: rtl/uart_tx_host.sv
// rtl/uart_tx_host.sv - Register-configured UART transmitter with byte FIFO and baud divider.
// Optional parity generation is enabled by defining UART_TX_PARITY_EN.
module uart_tx_host #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd15,
    parameter int          STOP_BITS   = 1
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        configure,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_DIV    = 8'h08;
    localparam logic [7:0] A_TXDATA = 8'h0C;

    localparam logic STOP_LAST = (STOP_BITS > 1) ? 1'b1 : 1'b0;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tx_en_q, tx_en_d, par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic [15:0]   div_q, div_d, div_sh_q, div_sh_d, baud_q, baud_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    state_q, state_d, bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          fpar_en_q, fpar_en_d, fpar_bit_q, fpar_bit_d;
    logic          tx_q, tx_d;
    logic [31:0]   data_out_q, rdata;

    logic          wr_ctrl, wr_status, wr_div, wr_txdata, flush;
    logic          fifo_full, fifo_empty, push_req, push, pop, tick;
    logic [31:0]   count_ext;
    logic [3:0]    fill;
    logic          unused_bits;

    assign unused_bits = ^{addr[31:8], data_in[31:16]};

    assign wr_ctrl   = configure && (addr[7:0] == A_CTRL);
    assign wr_status = configure && (addr[7:0] == A_STATUS);
    assign wr_div    = configure && (addr[7:0] == A_DIV);
    assign wr_txdata = configure && (addr[7:0] == A_TXDATA);
    assign flush     = wr_ctrl && data_in[1];

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign count_ext  = 32'(count_q);
    assign fill       = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_req = wr_txdata && !flush;
    assign push     = push_req && (!fifo_full || pop);
    assign tick     = (baud_q == 16'd0);

    always_comb begin
        tx_en_d    = tx_en_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        div_d      = div_q;
        overflow_d = overflow_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (wr_ctrl) begin
            tx_en_d = data_in[0];
`ifdef UART_TX_PARITY_EN
            par_en_d  = data_in[2];
            par_odd_d = data_in[3];
`else
            par_en_d  = 1'b0;
            par_odd_d = 1'b0;
`endif
        end
        if (wr_div) div_d = data_in[15:0];
        if (wr_status && data_in[3]) overflow_d = 1'b0;
        if (push_req && !push) overflow_d = 1'b1;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        baud_d     = baud_q;
        div_sh_d   = div_sh_q;
        fpar_en_d  = fpar_en_q;
        fpar_bit_d = fpar_bit_q;
        pop        = 1'b0;
        if (state_q == S_IDLE) begin
            // Divider and parity settings are frozen for the whole frame here.
            if (tx_en_q && !fifo_empty && !flush) begin
                pop        = 1'b1;
                shift_d    = mem_q[rptr_q];
                div_sh_d   = div_q;
                baud_d     = div_q;
                fpar_en_d  = par_en_q;
                fpar_bit_d = (^mem_q[rptr_q]) ^ par_odd_q;
                state_d    = S_START;
            end
        end else if (!tick) begin
            baud_d = baud_q - 16'd1;
        end else begin
            baud_d = div_sh_q;
            case (state_q)
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
                S_DATA: begin
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (fpar_en_q) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
                default: begin
                    if (stop_idx_q == STOP_LAST) state_d = S_IDLE;
                    else                         stop_idx_d = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_idx_d];
            S_PARITY: tx_d = fpar_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr[7:0])
            A_CTRL:   rdata = {28'd0, par_odd_q, par_en_q, 1'b0, tx_en_q};
            A_STATUS: rdata = {24'd0, fill, overflow_q, fifo_empty, fifo_full, (state_q != S_IDLE)};
            A_DIV:    rdata = {16'd0, div_q};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            tx_en_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            div_q      <= DEFAULT_DIV;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            baud_q     <= 16'd0;
            div_sh_q   <= DEFAULT_DIV;
            fpar_en_q  <= 1'b0;
            fpar_bit_q <= 1'b0;
            tx_q       <= 1'b1;
            data_out_q <= 32'd0;
        end else begin
            tx_en_q    <= tx_en_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            baud_q     <= baud_d;
            div_sh_q   <= div_sh_d;
            fpar_en_q  <= fpar_en_d;
            fpar_bit_q <= fpar_bit_d;
            tx_q       <= tx_d;
            data_out_q <= rdata;
        end
    end

    assign tx       = tx_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_tx_host.sv
// tb/tb_uart_tx_host.sv - Self-checking bench for uart_tx_host with a serial receive model.
`timescale 1ns/1ps
module tb_uart_tx_host;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h04, A_DIV = 8'h08, A_TXDATA = 8'h0C;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        configure = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        tx;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int mon_div = 15;
    bit mon_par = 1'b0;
    logic [7:0] rx_q[$];
    int start_cycles[$];

    uart_tx_host #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(16'd15), .STOP_BITS(1)) dut (
        .clk(clk), .srst_n(srst_n), .configure(configure), .addr(addr),
        .data_in(data_in), .data_out(data_out), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: detects a falling edge and samples each bit at its midpoint.
    initial begin : uart1_model
        logic prev;
        logic [7:0] b;
        prev = 1'b1;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                start_cycles.push_back(cyc);
                repeat ((mon_div + 1) / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (mon_div + 1) @(negedge clk);
                    b[k] = tx;
                end
                if (mon_par) repeat (mon_div + 1) @(negedge clk);
                repeat (mon_div + 1) @(negedge clk);
                rx_q.push_back(b);
            end
            prev = tx;
        end
    end

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        configure = 1'b1;
        addr = {24'd0, a};
        data_in = d;
        @(posedge clk);
        #1 configure = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        configure = 1'b0;
        addr = {24'd0, a};
        @(negedge clk);
        d = data_out;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_cycles.delete();
    endtask

    // Expected line level per clock, starting at the first START clock; idle (1) after the frame.
    task automatic make_frame(input logic [7:0] b, input int d, input bit par, input bit odd,
                              output logic [127:0] w, output int len);
        bit lv[$];
        lv.push_back(1'b0);
        for (int k = 0; k < 8; k++) lv.push_back(b[k]);
        if (par) lv.push_back((($countones(b) % 2) == 1) ^ odd);
        lv.push_back(1'b1);
        w = '1;
        len = lv.size() * (d + 1);
        for (int i = 0; i < lv.size(); i++)
            for (int j = 0; j <= d; j++) w[i * (d + 1) + j] = lv[i];
    endtask

    task automatic capture(input int len, output logic [127:0] w, output logic [127:0] bz, output bit ok);
        int n;
        w = '1;
        bz = '0;
        ok = 1'b0;
        n = 0;
        while (n < 300 && !ok) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            for (int i = 0; i < len + 2; i++) begin
                if (i > 0) @(negedge clk);
                w[i] = tx;
                bz[i] = data_out[0];
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        srst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests_run++;
        if (data_out !== 32'd0) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        srst_n = 1'b1;
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL reset_status: got %h expected 00000004", r); end
        reg_read(A_DIV, r);
        tests_run++;
        if (r !== 32'hF) begin tests_failed++; $display("FAIL reset_div: got %h expected 0000000f", r); end
        reg_read(A_CTRL, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected 0", r); end
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        reg_write(8'h10, $urandom);
        reg_read(8'h10, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read: got %h expected 0", r); end
        reg_read(A_TXDATA, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL txdata_read: got %h expected 0", r); end
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL unmapped_side_effect: status %h expected 00000004", r); end
    endtask

    task automatic test_single_byte();
        logic [127:0] ew, gw, eb, gb;
        logic [7:0] b, sent[$];
        int len, d;
        bit ok, same;
        clear_mon();
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin b = 8'h55; d = 3; end
            else begin b = 8'($urandom); d = int'($urandom_range(0, 4)); end
            mon_div = d;
            mon_par = 1'b0;
            reg_write(A_DIV, 32'(d));
            reg_write(A_CTRL, 32'h1);
            reg_write(A_TXDATA, {24'd0, b});
            addr = {24'd0, A_STATUS};
            make_frame(b, d, 1'b0, 1'b0, ew, len);
            capture(len, gw, gb, ok);
            sent.push_back(b);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL single_start it=%0d: no start bit within budget, expected one", it);
            end else begin
                tests_run++;
                if (gw !== ew) begin
                    tests_failed++;
                    $display("FAIL single_wave it=%0d byte=%h div=%0d: got %h expected %h", it, b, d, gw, ew);
                end
                if (it == 0) begin
                    eb = '0;
                    for (int i = 1; i <= len; i++) eb[i] = 1'b1;
                    tests_run++;
                    if (gb !== eb) begin tests_failed++; $display("FAIL single_busy: got %h expected %h", gb, eb); end
                end
            end
        end
        same = (rx_q.size() == sent.size());
        for (int i = 0; i < sent.size(); i++) if (same && rx_q[i] !== sent[i]) same = 1'b0;
        tests_run++;
        if (!same) begin
            tests_failed++;
            $display("FAIL single_rx: got %0d bytes (first %h) expected %0d bytes (first %h)",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0, sent.size(), sent[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        int d, n, gap;
        bit same;
        for (int round = 0; round < 2; round++) begin
            clear_mon();
            sent.delete();
            if (round == 0) begin d = 1; sent.push_back(8'h40); sent.push_back(8'h24); end
            else begin
                d = int'($urandom_range(0, 3));
                for (int i = 0; i < 4; i++) sent.push_back(8'($urandom));
            end
            mon_div = d;
            mon_par = 1'b0;
            reg_write(A_DIV, 32'(d));
            for (int i = 0; i < sent.size(); i++) reg_write(A_TXDATA, {24'd0, sent[i]});
            n = sent.size();
            gap = 10 * (d + 1) + 1;
            repeat (n * gap + 20) @(negedge clk);
            same = (start_cycles.size() == n);
            for (int i = 1; i < start_cycles.size(); i++)
                if (same && (start_cycles[i] - start_cycles[i-1]) != gap) same = 1'b0;
            tests_run++;
            if (!same) begin
                tests_failed++;
                $display("FAIL b2b_gap round=%0d: got %0d starts, second at +%0d; expected %0d starts spaced %0d",
                         round, start_cycles.size(),
                         (start_cycles.size() > 1) ? start_cycles[1] - start_cycles[0] : -1, n, gap);
            end
            same = (rx_q.size() == n);
            for (int i = 0; i < n; i++) if (same && rx_q[i] !== sent[i]) same = 1'b0;
            tests_run++;
            if (!same) begin
                tests_failed++;
                $display("FAIL b2b_rx round=%0d: got %0d bytes (first %h) expected %0d (first %h)",
                         round, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0, n, sent[0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] model[$];
        logic [7:0] b;
        logic [31:0] r;
        int polls;
        bit same;
        clear_mon();
        mon_div = 1;
        mon_par = 1'b0;
        reg_write(A_CTRL, 32'h0);
        reg_write(A_DIV, 32'h1);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'($urandom);
            reg_write(A_TXDATA, {24'd0, b});
            if (model.size() < FIFO_DEPTH) model.push_back(b);
        end
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h8A) begin tests_failed++; $display("FAIL ovf_status: got %h expected 0000008a", r); end
        b = 8'($urandom);
        reg_write(A_CTRL, 32'h1);
        reg_write(A_TXDATA, {24'd0, b});
        model.push_back(b);
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h8B) begin tests_failed++; $display("FAIL ovf_push_pop: got %h expected 0000008b", r); end
        reg_write(A_STATUS, 32'h8);
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h83) begin tests_failed++; $display("FAIL ovf_clear: got %h expected 00000083", r); end
        polls = 0;
        r = 32'h0;
        while (polls < 300 && r !== 32'h4) begin reg_read(A_STATUS, r); polls++; end
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL ovf_drain: status %h expected 00000004", r); end
        repeat (5) @(negedge clk);
        same = (rx_q.size() == model.size());
        for (int i = 0; i < model.size(); i++) if (same && rx_q[i] !== model[i]) same = 1'b0;
        tests_run++;
        if (!same) begin
            tests_failed++;
            $display("FAIL ovf_rx: got %0d bytes (last %h) expected %0d (last %h)",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h0, model.size(), b);
        end
    endtask

    task automatic test_flush();
        logic [7:0] b0;
        logic [31:0] r;
        clear_mon();
        mon_div = 3;
        mon_par = 1'b0;
        reg_write(A_DIV, 32'h3);
        reg_write(A_CTRL, 32'h1);
        b0 = 8'($urandom);
        reg_write(A_TXDATA, {24'd0, b0});
        reg_write(A_TXDATA, $urandom & 32'hFF);
        reg_write(A_TXDATA, $urandom & 32'hFF);
        repeat (11) @(posedge clk);
        reg_write(A_CTRL, 32'h2);
        repeat (80) @(negedge clk);
        tests_run++;
        if (start_cycles.size() != 1) begin
            tests_failed++;
            $display("FAIL flush_starts: got %0d frames expected 1", start_cycles.size());
        end
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== b0) begin
            tests_failed++;
            $display("FAIL flush_frame: got %0d bytes (first %h) expected 1 byte %h",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0, b0);
        end
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL flush_status: got %h expected 00000004", r); end
        reg_read(A_CTRL, r);
        tests_run++;
        if (r !== 32'h0) begin tests_failed++; $display("FAIL flush_ctrl: got %h expected 0", r); end
    endtask

    task automatic test_parity();
        logic [127:0] ew, gw, gb;
        logic [31:0] r, exp_ctrl;
        logic [7:0] bytes[2];
        int len;
        bit ok;
        clear_mon();
        mon_div = 3;
        mon_par = HAS_PAR;
        bytes[0] = 8'h07;
        bytes[1] = 8'($urandom);
        reg_write(A_DIV, 32'h3);
        for (int it = 0; it < 2; it++) begin
            reg_write(A_CTRL, (it == 0) ? 32'hD : 32'h5);
            reg_read(A_CTRL, r);
            exp_ctrl = HAS_PAR ? ((it == 0) ? 32'hD : 32'h5) : 32'h1;
            tests_run++;
            if (r !== exp_ctrl) begin tests_failed++; $display("FAIL parity_ctrl it=%0d: got %h expected %h", it, r, exp_ctrl); end
            reg_write(A_TXDATA, {24'd0, bytes[it]});
            make_frame(bytes[it], 3, HAS_PAR, (it == 0), ew, len);
            capture(len, gw, gb, ok);
            tests_run++;
            if (!ok || gw !== ew) begin
                tests_failed++;
                $display("FAIL parity_wave it=%0d byte=%h: got %h expected %h (start seen %0d)", it, bytes[it], gw, ew, ok);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (rx_q.size() != 2 || rx_q[0] !== bytes[0] || rx_q[1] !== bytes[1]) begin
            tests_failed++;
            $display("FAIL parity_rx: got %0d bytes (first %h) expected 2 bytes %h %h",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0, bytes[0], bytes[1]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        reg_write(A_DIV, 32'h3);
        reg_write(A_CTRL, 32'h1);
        reg_write(A_TXDATA, 32'h00);
        reg_write(A_TXDATA, $urandom & 32'hFF);
        repeat (6) @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL midreset_tx: got %b expected 1", tx); end
        srst_n = 1'b1;
        reg_read(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin tests_failed++; $display("FAIL midreset_status: got %h expected 00000004", r); end
        reg_read(A_DIV, r);
        tests_run++;
        if (r !== 32'hF) begin tests_failed++; $display("FAIL midreset_div: got %h expected 0000000f", r); end
        repeat (60) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL midreset_idle: got %b expected 1", tx); end
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_parity();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
